// File: rtl/timer_regs_pkg.sv
// Register map, control-bit positions and FSM encodings shared by the
// interval-timer bus master and anything else that talks to the timer slave.
package timer_regs_pkg;

    localparam logic [3:0] TMR_STATUS  = 4'd0;
    localparam logic [3:0] TMR_CONTROL = 4'd1;
    localparam logic [3:0] TMR_PERIOD0 = 4'd2;
    localparam logic [3:0] TMR_PERIOD1 = 4'd3;
    localparam logic [3:0] TMR_PERIOD2 = 4'd4;
    localparam logic [3:0] TMR_PERIOD3 = 4'd5;
    localparam logic [3:0] TMR_SNAP0   = 4'd6;
    localparam logic [3:0] TMR_SNAP1   = 4'd7;
    localparam logic [3:0] TMR_SNAP2   = 4'd8;
    localparam logic [3:0] TMR_SNAP3   = 4'd9;

    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;

    typedef enum logic [1:0] {
        OP_LOAD_PERIOD = 2'd0,
        OP_START       = 2'd1,
        OP_STOP        = 2'd2,
        OP_SNAPSHOT    = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_PER   = 3'd1,
        ST_WR_CTRL  = 3'd2,
        ST_WR_SNAP  = 3'd3,
        ST_RD_SNAP  = 3'd4,
        ST_RD_DRAIN = 3'd5,
        ST_ACK_IRQ  = 3'd6
    } state_e;

    function automatic logic [15:0] ctrl_word(input logic stop_bit, input logic start_bit,
                                              input logic cont_bit, input logic ie_bit);
        logic [15:0] w;
        w        = 16'h0000;
        w[STOP]  = stop_bit;
        w[START] = start_bit;
        w[CONT]  = cont_bit;
        w[ITO]   = ie_bit;
        return w;
    endfunction

    function automatic logic [15:0] halfword(input logic [63:0] v, input logic [1:0] idx);
        return v[{idx, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/timer_bus_master_if.sv
// Avalon-MM style halfword register port between the bus master and the
// interval-timer slave (no waitrequest, read latency of one cycle).
interface timer_bus_master_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [15:0]       writedata;
    logic [15:0]       readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/timer_bus_master.sv
// Command sequencer for the 64-bit interval timer: turns load/start/stop/snapshot
// requests into halfword register beats and services the timer interrupt.
module timer_bus_master
    import timer_regs_pkg::*;
#(
    parameter bit AUTO_ACK = 1'b1,
    parameter int ADDR_W   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [63:0] cmd_period,
    input  logic        cmd_continuous,
    input  logic        cmd_irq_en,
    output logic        snap_valid,
    output logic [63:0] snap_value,
    output logic        timeout_pulse,
    input  logic        irq_in,
    timer_bus_master_if.master bus
);

    state_e            state_r;
    logic [1:0]        idx_r;
    logic [63:0]       period_r;
    logic              cont_r;
    logic              ie_r;
    logic              ack_hold_r;
    logic [15:0]       shadow_r [0:2];
    logic [ADDR_W-1:0] addr_r;
    logic              cs_r;
    logic              wn_r;
    logic [15:0]       wdata_r;
    logic              snap_valid_r;
    logic [63:0]       snap_value_r;
    logic              timeout_r;

    logic              irq_take_s;
    logic              cmd_ready_s;
    logic              accept_s;
    logic [1:0]        idx_inc_s;

    // Interrupt qualification and command handshake; irq wins over a waiting command.
    always_comb begin
        irq_take_s  = 1'b0;
        cmd_ready_s = 1'b0;
        if (AUTO_ACK && irq_in && !ack_hold_r) begin
            irq_take_s = 1'b1;
        end else begin
            irq_take_s = 1'b0;
        end
        if ((state_r == ST_IDLE) && !irq_take_s) begin
            cmd_ready_s = 1'b1;
        end else begin
            cmd_ready_s = 1'b0;
        end
        accept_s  = cmd_valid && cmd_ready_s;
        idx_inc_s = idx_r + 2'd1;
    end

    // Sequencer: state, halfword counter, captured data and all registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= 2'd0;
            period_r     <= 64'd0;
            cont_r       <= 1'b0;
            ie_r         <= 1'b0;
            ack_hold_r   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                shadow_r[i] <= 16'h0000;
            end
            addr_r       <= '0;
            cs_r         <= 1'b0;
            wn_r         <= 1'b1;
            wdata_r      <= 16'h0000;
            snap_valid_r <= 1'b0;
            snap_value_r <= 64'd0;
            timeout_r    <= 1'b0;
        end else begin
            // Bus returns to idle unless the next state issues a beat.
            addr_r       <= '0;
            cs_r         <= 1'b0;
            wn_r         <= 1'b1;
            wdata_r      <= 16'h0000;
            snap_valid_r <= 1'b0;
            timeout_r    <= 1'b0;
            ack_hold_r   <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (irq_take_s) begin
                        state_r   <= ST_ACK_IRQ;
                        addr_r    <= ADDR_W'(TMR_STATUS);
                        cs_r      <= 1'b1;
                        wn_r      <= 1'b0;
                        timeout_r <= 1'b1;
                    end else if (accept_s) begin
                        case (cmd_op_e'(cmd_op))
                            OP_LOAD_PERIOD: begin
                                state_r  <= ST_WR_PER;
                                period_r <= cmd_period;
                                idx_r    <= 2'd0;
                                addr_r   <= ADDR_W'(TMR_PERIOD0);
                                cs_r     <= 1'b1;
                                wn_r     <= 1'b0;
                                wdata_r  <= cmd_period[15:0];
                            end
                            OP_START: begin
                                state_r <= ST_WR_CTRL;
                                cont_r  <= cmd_continuous;
                                ie_r    <= cmd_irq_en;
                                addr_r  <= ADDR_W'(TMR_CONTROL);
                                cs_r    <= 1'b1;
                                wn_r    <= 1'b0;
                                wdata_r <= ctrl_word(1'b0, 1'b1, cmd_continuous, cmd_irq_en);
                            end
                            OP_STOP: begin
                                state_r <= ST_WR_CTRL;
                                addr_r  <= ADDR_W'(TMR_CONTROL);
                                cs_r    <= 1'b1;
                                wn_r    <= 1'b0;
                                wdata_r <= ctrl_word(1'b1, 1'b0, cont_r, ie_r);
                            end
                            OP_SNAPSHOT: begin
                                state_r <= ST_WR_SNAP;
                                addr_r  <= ADDR_W'(TMR_SNAP0);
                                cs_r    <= 1'b1;
                                wn_r    <= 1'b0;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR_PER: begin
                    if (idx_r == 2'd3) begin
                        state_r <= ST_IDLE;
                    end else begin
                        idx_r   <= idx_inc_s;
                        addr_r  <= ADDR_W'(TMR_PERIOD0 + {2'b00, idx_inc_s});
                        cs_r    <= 1'b1;
                        wn_r    <= 1'b0;
                        wdata_r <= halfword(period_r, idx_inc_s);
                    end
                end
                ST_WR_CTRL: begin
                    state_r <= ST_IDLE;
                end
                ST_WR_SNAP: begin
                    state_r <= ST_RD_SNAP;
                    idx_r   <= 2'd0;
                    addr_r  <= ADDR_W'(TMR_SNAP0);
                    cs_r    <= 1'b1;
                end
                ST_RD_SNAP: begin
                    // readdata now carries the halfword addressed one beat earlier.
                    if (idx_r != 2'd0) begin
                        shadow_r[idx_r - 2'd1] <= bus.readdata;
                    end else begin
                        shadow_r[0] <= shadow_r[0];
                    end
                    if (idx_r == 2'd3) begin
                        state_r <= ST_RD_DRAIN;
                    end else begin
                        idx_r  <= idx_inc_s;
                        addr_r <= ADDR_W'(TMR_SNAP0 + {2'b00, idx_inc_s});
                        cs_r   <= 1'b1;
                    end
                end
                ST_RD_DRAIN: begin
                    state_r      <= ST_IDLE;
                    snap_value_r <= {bus.readdata, shadow_r[2], shadow_r[1], shadow_r[0]};
                    snap_valid_r <= 1'b1;
                end
                ST_ACK_IRQ: begin
                    // irq_in only falls a cycle after the clear lands in the slave.
                    state_r    <= ST_IDLE;
                    ack_hold_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready      = cmd_ready_s;
    assign snap_valid     = snap_valid_r;
    assign snap_value     = snap_value_r;
    assign timeout_pulse  = timeout_r;
    assign bus.address    = addr_r;
    assign bus.chipselect = cs_r;
    assign bus.write_n    = wn_r;
    assign bus.writedata  = wdata_r;

endmodule

// File: tb/tb_timer_bus_master.sv
// Scoreboard bench for timer_bus_master: a behavioural timer-slave model plus
// expected-beat queues filled at command acceptance and drained by a monitor.
module tb_timer_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_period;
    logic        cmd_continuous;
    logic        cmd_irq_en;
    logic        snap_valid;
    logic [63:0] snap_value;
    logic        timeout_pulse;
    logic        irq_lvl = 1'b0;
    logic        irq_req;

    logic        cmd_valid2 = 1'b0;
    logic        cmd_ready2;
    logic        snap_valid2;
    logic [63:0] snap_value2;
    logic        timeout_pulse2;

    timer_bus_master_if #(.ADDR_W(4)) bus ();
    timer_bus_master_if #(.ADDR_W(4)) bus2 ();

    timer_bus_master #(.AUTO_ACK(1'b1), .ADDR_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
        .snap_valid(snap_valid), .snap_value(snap_value),
        .timeout_pulse(timeout_pulse), .irq_in(irq_lvl), .bus(bus)
    );

    timer_bus_master #(.AUTO_ACK(1'b0), .ADDR_W(4)) dut_noack (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_op(cmd_op),
        .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
        .snap_valid(snap_valid2), .snap_value(snap_value2),
        .timeout_pulse(timeout_pulse2), .irq_in(irq_lvl), .bus(bus2)
    );
    assign bus2.readdata = 16'h0000;

    // Timer slave: registered read data, snapshot registers, irq cleared by a status write.
    logic [15:0] mem [0:15];
    logic [15:0] snap_regs [0:3];
    always @(posedge clk) begin
        if (bus.chipselect && !bus.write_n) mem[bus.address] <= bus.writedata;
        if (bus.chipselect && bus.write_n)
            bus.readdata <= (bus.address >= 4'd6) ? snap_regs[bus.address - 4'd6] : mem[bus.address];
        if (bus.chipselect && !bus.write_n && bus.address == 4'd0) irq_lvl <= 1'b0;
        else if (irq_req) irq_lvl <= 1'b1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [3:0] addr; logic [15:0] data; int cyc; } beat_t;
    typedef struct { logic [63:0] val; int cyc; } snap_t;
    beat_t exp_wr[$];
    beat_t exp_rd[$];
    snap_t exp_snap[$];
    beat_t mon_b;
    snap_t mon_s;

    int checks = 0;
    int failures = 0;
    int acks_seen = 0;
    int irq_raised = 0;
    int last_ack_cyc = -1;
    logic model_cont = 1'b0;
    logic model_ie = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every bus beat and pulse the DUT presents is matched against the queues.
    always @(negedge clk) begin
        if (bus.chipselect && !bus.write_n) begin
            if (bus.address == 4'd0) begin
                check("ack_data", {48'd0, bus.writedata}, 64'd0);
                check("ack_pulse", {63'd0, timeout_pulse}, 64'd1);
                acks_seen++;
                last_ack_cyc = cyc;
            end else if (exp_wr.size() == 0) begin
                check("unexpected_write_addr", {60'd0, bus.address}, 64'hF);
            end else begin
                mon_b = exp_wr.pop_front();
                check("wr_addr", {60'd0, bus.address}, {60'd0, mon_b.addr});
                check("wr_data", {48'd0, bus.writedata}, {48'd0, mon_b.data});
                check("wr_cycle", 64'(cyc), 64'(mon_b.cyc));
            end
        end else if (timeout_pulse) begin
            check("pulse_without_ack", {63'd0, timeout_pulse}, 64'd0);
        end
        if (bus.chipselect && bus.write_n) begin
            if (exp_rd.size() == 0) begin
                check("unexpected_read_addr", {60'd0, bus.address}, 64'hF);
            end else begin
                mon_b = exp_rd.pop_front();
                check("rd_addr", {60'd0, bus.address}, {60'd0, mon_b.addr});
                check("rd_cycle", 64'(cyc), 64'(mon_b.cyc));
            end
        end
        if (snap_valid) begin
            if (exp_snap.size() == 0) begin
                check("unexpected_snap", snap_value, 64'hDEAD);
            end else begin
                mon_s = exp_snap.pop_front();
                check("snap_value", snap_value, mon_s.val);
                check("snap_cycle", 64'(cyc), 64'(mon_s.cyc));
            end
        end
        if (irq_lvl) begin
            check("noack_pulse", {63'd0, timeout_pulse2}, 64'd0);
            check("noack_cs", {63'd0, bus2.chipselect}, 64'd0);
            check("noack_ready", {63'd0, cmd_ready2}, 64'd1);
        end
    end

    // Present one command, wait (bounded) for acceptance, then queue the bus activity it implies.
    // For SNAPSHOT, 'per' is the 64-bit value the slave's snapshot registers will hold.
    task automatic issue(input logic [1:0] op, input logic [63:0] per,
                         input logic cont, input logic ie, output int acc);
        int n;
        n = 0;
        acc = -1;
        cmd_op = op; cmd_period = per; cmd_continuous = cont; cmd_irq_en = ie;
        cmd_valid = 1'b1;
        while (acc < 0 && n < 64) begin
            @(negedge clk);
            if (cmd_ready) acc = cyc;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (acc < 0) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            case (op)
                2'd0: for (int i = 0; i < 4; i++)
                          exp_wr.push_back('{4'(2 + i), per[16*i +: 16], acc + 1 + i});
                2'd1: begin
                    model_cont = cont; model_ie = ie;
                    exp_wr.push_back('{4'd1, {12'd0, 1'b0, 1'b1, cont, ie}, acc + 1});
                end
                2'd2: exp_wr.push_back('{4'd1, {12'd0, 1'b1, 1'b0, model_cont, model_ie}, acc + 1});
                default: begin
                    for (int i = 0; i < 4; i++) snap_regs[i] = per[16*i +: 16];
                    exp_wr.push_back('{4'd6, 16'h0000, acc + 1});
                    for (int i = 0; i < 4; i++) exp_rd.push_back('{4'(6 + i), 16'h0000, acc + 2 + i});
                    // Acceptance cycle is index 0: six busy cycles, pulse in the seventh.
                    exp_snap.push_back('{per, acc + 7});
                end
            endcase
        end
    endtask

    task automatic raise_irq();
        if (irq_lvl == 1'b0) begin
            irq_req = 1'b1;
            irq_raised++;
            @(posedge clk); #1;
            irq_req = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int acc_a, acc_b, acks_before;

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; irq_req = 1'b0;
        cmd_op = 2'd0; cmd_period = 64'd0; cmd_continuous = 1'b0; cmd_irq_en = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 4; i++) snap_regs[i] = 16'h0000;
        #12;
        check("rst_cs", {63'd0, bus.chipselect}, 64'd0);
        check("rst_write_n", {63'd0, bus.write_n}, 64'd1);
        check("rst_addr", {60'd0, bus.address}, 64'd0);
        check("rst_wdata", {48'd0, bus.writedata}, 64'd0);
        check("rst_snap_valid", {63'd0, snap_valid}, 64'd0);
        check("rst_snap_value", snap_value, 64'd0);
        check("rst_timeout", {63'd0, timeout_pulse}, 64'd0);
        check("rst_ready", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2);

        // Period load immediately followed by START: ready must be low for exactly four cycles.
        issue(2'd0, 64'h0000_0001_0002_0003, 1'b0, 1'b0, acc_a);
        issue(2'd1, 64'd0, 1'b1, 1'b1, acc_b);
        check("load_busy_cycles", 64'(acc_b - acc_a), 64'd5);
        issue(2'd2, 64'd0, 1'b0, 1'b0, acc_a);
        issue(2'd3, 64'h4444_3333_2222_1111, 1'b0, 1'b0, acc_a);
        idle(8);

        // irq pending while idle takes priority over a waiting command.
        raise_irq();
        @(negedge clk);
        check("ready_low_on_irq", {63'd0, cmd_ready}, 64'd0);
        acks_before = acks_seen;
        issue(2'd1, 64'd0, 1'b0, 1'b1, acc_a);
        check("ack_before_cmd", 64'(last_ack_cyc < acc_a && acks_seen == acks_before + 1), 64'd1);
        idle(3);

        // irq arriving mid-snapshot: snapshot timing untouched, exactly one ack afterwards.
        acks_before = acks_seen;
        issue(2'd3, {$urandom, $urandom}, 1'b0, 1'b0, acc_a);
        idle(1);
        raise_irq();
        idle(12);
        check("ack_once_after_snap", 64'(acks_seen - acks_before), 64'd1);

        for (int k = 0; k < 80; k++) begin
            issue(2'($urandom_range(0, 3)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc_a);
            if ($urandom_range(0, 3) == 0) raise_irq();
            idle($urandom_range(0, 3));
        end
        idle(12);

        // Reset during the second period beat: bus idles at once, stored ctrl bits cleared.
        issue(2'd0, {$urandom, $urandom}, 1'b0, 1'b0, acc_a);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("midrst_cs", {63'd0, bus.chipselect}, 64'd0);
        check("midrst_write_n", {63'd0, bus.write_n}, 64'd1);
        check("midrst_addr", {60'd0, bus.address}, 64'd0);
        check("midrst_wdata", {48'd0, bus.writedata}, 64'd0);
        exp_wr.delete();
        model_cont = 1'b0; model_ie = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        check("midrst_ready", {63'd0, cmd_ready}, 64'd1);
        issue(2'd2, 64'd0, 1'b0, 1'b0, acc_a);
        idle(12);

        check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        check("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
        check("snap_queue_empty", 64'(exp_snap.size()), 64'd0);
        check("ack_count", 64'(acks_seen), 64'(irq_raised));
        check("irq_cleared", {63'd0, irq_lvl}, 64'd0);
        check("noack_snap_value", snap_value2, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
